// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into a 2-entry skid buffer feeding the ALU.
// Optional `ALU_FWD_EN adds writeback forwarding ports (wb_valid/wb_rd/wb_data).
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
`ifdef ALU_FWD_EN
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_op,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } payload_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic            w_shift;
  logic            w_legal;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  payload_t        w_dec_p0;
  logic            w_accept;
  logic            w_consume;

  state_t   r_state;
  payload_t r_main_p1;
  payload_t r_skid_p1;

  assign w_opc   = instr[6:0];
  assign w_f3    = instr[14:12];
  assign w_f7    = instr[31:25];
  assign w_rd    = instr[11:7];
  assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

`ifdef ALU_FWD_EN
  assign w_rs1 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[19:15]) ? wb_data : rs1_val;
  assign w_rs2 = (wb_valid && wb_rd != 5'd0 && wb_rd == instr[24:20]) ? wb_data : rs2_val;
`else
  assign w_rs1 = rs1_val;
  assign w_rs2 = rs2_val;
`endif

  // Stage p0: combinational decode of the offered instruction
  always_comb begin
    w_dec_p0 = '0;
    w_legal  = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_legal     = (w_f7 == 7'd0) || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
        w_dec_p0.a  = w_rs1;
        w_dec_p0.b  = w_rs2;
        w_dec_p0.op = alu_op(w_f3, w_f7 == F7_ALT);
      end
      OPC_OPIMM: begin
        // ADDI carries immediate bits in funct7, so only shifts may select the alternate op
        w_legal     = !(w_shift && instr[25]) && !(w_f3 == 3'b001 && w_f7 != 7'd0);
        w_dec_p0.a  = w_rs1;
        w_dec_p0.b  = w_shift ? {{(XLEN-5){1'b0}}, instr[24:20]}
                              : {{(XLEN-12){instr[31]}}, instr[31:20]};
        w_dec_p0.op = alu_op(w_f3, w_f3 == 3'b101 && w_f7 == F7_ALT);
      end
      OPC_LUI: begin
        w_legal     = 1'b1;
        w_dec_p0.b  = {instr[31:12], 12'b0};
        w_dec_p0.op = ALU_ADD;
      end
      OPC_AUIPC: begin
        w_legal     = 1'b1;
        w_dec_p0.a  = pc;
        w_dec_p0.b  = {instr[31:12], 12'b0};
        w_dec_p0.op = ALU_ADD;
      end
      default: w_legal = 1'b0;
    endcase
    w_dec_p0.rd = w_rd;
    if (w_legal) begin
      w_dec_p0.we      = (w_rd != 5'd0);
      w_dec_p0.illegal = 1'b0;
    end else begin
      w_dec_p0.a       = '0;
      w_dec_p0.b       = '0;
      w_dec_p0.op      = ALU_AND;
      w_dec_p0.we      = 1'b0;
      w_dec_p0.illegal = 1'b1;
    end
  end

  assign in_ready  = (r_state != S_TWO) && !reset;
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  // Stage p1: main entry drives the ALU, skid entry absorbs one stalled accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_EMPTY;
      r_main_p1 <= '0;
      r_skid_p1 <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_p1 <= w_dec_p0;
            r_state   <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            r_main_p1 <= w_dec_p0;
          end else if (w_accept) begin
            r_skid_p1 <= w_dec_p0;
            r_state   <= S_TWO;
          end else if (w_consume) begin
            r_state   <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_consume) begin
            r_main_p1 <= r_skid_p1;
            r_state   <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign out_a       = r_main_p1.a;
  assign out_b       = r_main_p1.b;
  assign out_op      = r_main_p1.op;
  assign out_rd      = r_main_p1.rd;
  assign out_we      = r_main_p1.we;
  assign out_illegal = r_main_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed cases plus random traffic against a queue-based reference.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int   n_checks;
  int   n_fail;
  exp_t q[$];

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
`ifdef ALU_FWD_EN
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observed();
    observed = '{a: out_a, b: out_b, op: out_op, rd: out_rd, we: out_we, illegal: out_illegal};
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                      input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0] base_tbl [8];
    logic [31:0] v1, v2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, alt, is_shift;
    exp_t e;
    base_tbl = '{4'b0010, 4'b0111, 4'b1100, 4'b1101, 4'b0011, 4'b0110, 4'b0001, 4'b0000};
    v1 = r1;
    v2 = r2;
    if (wb_valid && wb_rd != 0 && wb_rd == ins[19:15]) v1 = wb_data;
    if (wb_valid && wb_rd != 0 && wb_rd == ins[24:20]) v2 = wb_data;
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '0;
    e.rd = ins[11:7];
    ok = 1'b0;
    alt = 1'b0;
    is_shift = (f3 == 1 || f3 == 5);
    if (ins[6:0] == 7'h33) begin
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      alt = (f7 == 7'h20);
      e.a = v1;
      e.b = v2;
    end else if (ins[6:0] == 7'h13) begin
      ok = !(is_shift && ins[25]) && !(f3 == 1 && f7 != 0);
      alt = (f3 == 5 && f7 == 7'h20);
      e.a = v1;
      e.b = is_shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
    end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
      ok = 1'b1;
      e.a = (ins[6:0] == 7'h17) ? pcv : 32'd0;
      e.b = ins & 32'hFFFF_F000;
      f3 = 3'b000;
    end
    e.op = base_tbl[f3];
    if (alt && e.op == 4'b0010) e.op = 4'b1010;
    if (alt && e.op == 4'b0110) e.op = 4'b1110;
    if (!ok) begin
      e.a = 0;
      e.b = 0;
      e.op = 4'b0000;
      e.illegal = 1'b1;
    end
    e.we = ok && (e.rd != 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive, compare at negedge, advance the reference queue at posedge
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic rst);
    logic acc, cons;
    exp_t d;
    in_valid = iv; instr = ins; pc = pcv; rs1_val = r1; rs2_val = r2;
    out_ready = ordy; reset = rst;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, (q.size() < 2) && !rst);
    if (q.size() > 0) chk("payload", observed(), q[0]);
    acc  = iv && (q.size() < 2) && !rst;
    cons = (q.size() > 0) && ordy;
    d = ref_decode(ins, pcv, r1, r2);
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    #1;
    if (rst) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_payload", observed(), 75'd0);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 7);
    case (sel)
      0, 1, 2: w[6:0] = 7'h33;
      3, 4:    w[6:0] = 7'h13;
      5:       w[6:0] = 7'h37;
      6:       w[6:0] = 7'h17;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    in_valid = 0; instr = 0; pc = 0; rs1_val = 0; rs2_val = 0; out_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_in_ready_in_reset", in_ready, 1'b0);
    chk("init_payload", observed(), 75'd0);
    reset = 0;
    #1;
    chk("init_in_ready", in_ready, 1'b1);

    cycle(1, 32'h002081B3, 0, 5, 7, 1, 0);
    chk("add_valid", out_valid, 1'b1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_op", out_op, 4'b0010);
    chk("add_rd", out_rd, 5'd3);
    chk("add_we", out_we, 1'b1);

    cycle(1, 32'h402081B3, 0, 9, 4, 1, 0);
    chk("sub_op", out_op, 4'b1010);
    cycle(1, 32'h4040D193, 0, 32'h8000_0000, 0, 1, 0);
    chk("srai_op", out_op, 4'b1110);
    chk("srai_b", out_b, 32'd4);
    cycle(1, 32'h123452B7, 0, 1, 2, 1, 0);
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_rd", out_rd, 5'd5);
    cycle(1, 32'h0000007F, 0, 1, 2, 1, 0);
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_we", out_we, 1'b0);
    chk("ill_op", out_op, 4'b0000);
    cycle(1, 32'h02009093, 0, 1, 2, 1, 0);
    chk("slli25_ill", out_illegal, 1'b1);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Back-pressure: three offers, two fit
    cycle(1, 32'h002081B3, 0, 32'h11, 1, 0, 0);
    cycle(1, 32'h002081B3, 0, 32'h22, 1, 0, 0);
    cycle(1, 32'h002081B3, 0, 32'h33, 1, 0, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", out_a, 32'h11);
    cycle(1, 32'h002081B3, 0, 32'h33, 1, 1, 0);
    chk("bp_second", out_a, 32'h22);
    cycle(1, 32'h002081B3, 0, 32'h33, 1, 1, 0);
    chk("bp_third", out_a, 32'h33);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Reset while both entries are full
    cycle(1, 32'h00310233, 0, 3, 4, 0, 0);
    cycle(1, 32'h00310233, 0, 5, 6, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);

`ifdef ALU_FWD_EN
    wb_valid = 1; wb_rd = 1; wb_data = 32'h99;
    cycle(1, 32'h002081B3, 0, 5, 7, 1, 0);
    chk("fwd_a", out_a, 32'h99);
    wb_valid = 0;
    cycle(0, 0, 0, 0, 0, 1, 0);
`endif

    for (int i = 0; i < 600; i++) begin
`ifdef ALU_FWD_EN
      wb_valid = $urandom_range(0, 1);
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
`endif
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    end
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
